// File: rtl/count_seq_ctrl_if.sv
// Control and status bundle for the counter sequencing controller.
// The master (system control) drives run requests and configuration; the slave returns count and status.
interface count_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             hold;
    logic             up;
    logic             periodic;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qo;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, hold, up, periodic, limit,
        input  q, qo, busy, tc, done
    );

    modport slave (
        input  start, stop, hold, up, periodic, limit,
        output q, qo, busy, tc, done
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Start/pause/stop sequencer for a modulo up/down counter with one-shot and periodic modes.
//
//  state  | meaning
//  IDLE   | no run active, q held at 0
//  RUN    | counting one step per cycle toward term
//  PAUSE  | run suspended by hold, q frozen
//  DONE   | one-shot run finished, q holds term
module count_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    count_seq_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] limit_r;
    logic             up_r;
    logic             per_r;
    logic             tc_r;

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] ld_term;
    logic [WIDTH-1:0] q_step;

    // Latched configuration governs the run; the raw inputs only matter on a start edge.
    assign start_val = up_r ? '0 : limit_r;
    assign term      = up_r ? limit_r : '0;
    assign ld_val    = bus.up ? '0 : bus.limit;
    assign ld_term   = bus.up ? bus.limit : '0;
    assign q_step    = up_r ? q_r + WIDTH'(1) : q_r - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            q_r     <= '0;
            tc_r    <= 1'b0;
            limit_r <= '0;
            up_r    <= 1'b0;
            per_r   <= 1'b0;
        end else begin
            tc_r <= 1'b0;
            if (bus.stop) begin
                state <= S_IDLE;
                q_r   <= '0;
            end else if (bus.start) begin
                limit_r <= bus.limit;
                up_r    <= bus.up;
                per_r   <= bus.periodic;
                q_r     <= ld_val;
                tc_r    <= (ld_val == ld_term);
                state   <= ((ld_val == ld_term) && !bus.periodic) ? S_DONE : S_RUN;
            end else begin
                case (state)
                    S_RUN: begin
                        if (bus.hold) begin
                            state <= S_PAUSE;
                        end else if (per_r && (q_r == term)) begin
                            q_r  <= start_val;
                            tc_r <= (start_val == term);
                        end else begin
                            q_r  <= q_step;
                            tc_r <= (q_step == term);
                            if (!per_r && (q_step == term)) begin
                                state <= S_DONE;
                            end
                        end
                    end
                    S_PAUSE: begin
                        // Release only resumes; the first advance follows one cycle later.
                        if (!bus.hold) begin
                            state <= S_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.qo   = ~q_r;
    assign bus.tc   = tc_r;
    assign bus.busy = (state == S_RUN) || (state == S_PAUSE);
    assign bus.done = (state == S_DONE);
endmodule
